// File: rtl/sifive_scope_dcache_resp_trace.sv
// DCache response trace scope: filters monitored responses, captures them into a
// circular buffer around an address trigger, then drains oldest-first for readout.
module sifive_scope_dcache_resp_trace #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 7,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int E_W   = TS_W + 10 + ID_W + ADDR_W + DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              resp_valid,
  input  logic              resp_miss,
  input  logic              resp_has_data,
  input  logic              resp_signed,
  input  logic [ADDR_W-1:0] resp_addr,
  input  logic [DATA_W-1:0] resp_rdata,
  input  logic [ID_W-1:0]   resp_id,
  input  logic [4:0]        resp_cmd,
  input  logic [1:0]        resp_size,
  input  logic [31:0]       cfg_cmd_mask,
  input  logic              cfg_miss_only,
  input  logic              cfg_trig_en,
  input  logic [ADDR_W-1:0] cfg_trig_addr,
  input  logic [ADDR_W-1:0] cfg_trig_mask,
  input  logic [PW-1:0]     cfg_post_cnt,
  input  logic              arm,
  input  logic              abort,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [E_W-1:0]    rd_data,
  output logic [1:0]        st_state,
  output logic [PW:0]       st_count,
  output logic              st_overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, POST = 2'd2, DONE = 2'd3} state_e;

  localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]     CNT_ONE  = 1;
  localparam logic [PW-1:0]   PTR_ONE  = 1;
  localparam logic [TS_W-1:0] TS_ONE   = 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     remain_q, remain_d;
  logic [PW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [TS_W-1:0]   ts_q;
  logic [E_W-1:0]    mem_q [DEPTH];

  logic              qual, hit, cap_en, pop;
  logic [E_W-1:0]    entry;
  logic [PW-1:0]     rptr;

  assign qual   = resp_valid & cfg_cmd_mask[resp_cmd] & (~cfg_miss_only | resp_miss);
  assign hit    = qual & cfg_trig_en & (((resp_addr ^ cfg_trig_addr) & cfg_trig_mask) == '0);
  assign cap_en = qual & ~abort & ((state_q == PRE) | (state_q == POST));
  assign entry  = {ts_q, resp_miss, resp_has_data, resp_signed, resp_size, resp_cmd,
                   resp_id, resp_addr, resp_rdata};

  // When full, count's low bits are zero, so the oldest entry sits at wptr itself.
  assign rptr     = wptr_q - count_q[PW-1:0];
  assign rd_valid = (state_q == DONE) && (count_q != '0);
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = mem_q[rptr];

  assign st_state    = state_q;
  assign st_count    = count_q;
  assign st_overflow = ovf_q;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    remain_d = remain_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d  = PRE;
          wptr_d   = '0;
          count_d  = '0;
          ovf_d    = 1'b0;
          remain_d = '0;
        end
      end
      PRE: begin
        if (hit) begin
          if (cfg_post_cnt == '0) begin
            state_d = DONE;
          end else begin
            state_d  = POST;
            remain_d = cfg_post_cnt;
          end
        end
      end
      POST: begin
        if (qual) begin
          remain_d = remain_q - PTR_ONE;
          if (remain_q == PTR_ONE) state_d = DONE;
        end
      end
      DONE: begin
        if (pop) count_d = count_q - CNT_ONE;
        if (arm) begin
          state_d  = PRE;
          wptr_d   = '0;
          count_d  = '0;
          ovf_d    = 1'b0;
          remain_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap_en) begin
      wptr_d = wptr_q + PTR_ONE;
      if (count_q == CNT_FULL) ovf_d = 1'b1;
      else                     count_d = count_q + CNT_ONE;
    end

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      remain_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ts_q     <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      remain_q <= remain_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ts_q     <= ts_q + TS_ONE;
    end
  end

  // Trace storage is never reset; count alone determines which entries are live.
  always_ff @(posedge clock) begin
    if (cap_en) mem_q[wptr_q] <= entry;
  end

endmodule

// File: tb/tb_sifive_scope_dcache_resp_trace.sv
// Directed bench for the DCache response trace scope (DEPTH=4).
module tb_sifive_scope_dcache_resp_trace;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 7;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 16;
  localparam int PW     = 2;
  localparam int E_W    = TS_W + 10 + ID_W + ADDR_W + DATA_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              resp_valid = 1'b0, resp_miss = 1'b0, resp_has_data = 1'b0, resp_signed = 1'b0;
  logic [ADDR_W-1:0] resp_addr = '0;
  logic [DATA_W-1:0] resp_rdata = '0;
  logic [ID_W-1:0]   resp_id = '0;
  logic [4:0]        resp_cmd = '0;
  logic [1:0]        resp_size = '0;
  logic [31:0]       cfg_cmd_mask = 32'hFFFF_FFFF;
  logic              cfg_miss_only = 1'b0;
  logic              cfg_trig_en = 1'b0;
  logic [ADDR_W-1:0] cfg_trig_addr = '0;
  logic [ADDR_W-1:0] cfg_trig_mask = 32'hFFFF_FFFF;
  logic [PW-1:0]     cfg_post_cnt = '0;
  logic              arm = 1'b0, abort = 1'b0, rd_ready = 1'b0;
  logic              rd_valid;
  logic [E_W-1:0]    rd_data;
  logic [1:0]        st_state;
  logic [PW:0]       st_count;
  logic              st_overflow;

  int tests = 0;
  int fails = 0;
  logic [E_W-1:0] exp_e;

  sifive_scope_dcache_resp_trace #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clock(clock), .reset(reset),
    .resp_valid(resp_valid), .resp_miss(resp_miss), .resp_has_data(resp_has_data),
    .resp_signed(resp_signed), .resp_addr(resp_addr), .resp_rdata(resp_rdata),
    .resp_id(resp_id), .resp_cmd(resp_cmd), .resp_size(resp_size),
    .cfg_cmd_mask(cfg_cmd_mask), .cfg_miss_only(cfg_miss_only),
    .cfg_trig_en(cfg_trig_en), .cfg_trig_addr(cfg_trig_addr),
    .cfg_trig_mask(cfg_trig_mask), .cfg_post_cnt(cfg_post_cnt),
    .arm(arm), .abort(abort),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .st_state(st_state), .st_count(st_count), .st_overflow(st_overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_resp(input logic [31:0] a, input logic [4:0] c, input logic m);
    resp_valid    = 1'b1;
    resp_addr     = a;
    resp_cmd      = c;
    resp_miss     = m;
    resp_has_data = 1'b1;
    resp_signed   = 1'b0;
    resp_size     = 2'd2;
    resp_id       = a[6:0];
    resp_rdata    = ~a;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++;
    if (st_state !== 2'd0 || st_count !== 3'd0 || st_overflow !== 1'b0 || rd_valid !== 1'b0) begin
      $display("FAIL reset_state: got state=%0d count=%0d ovf=%0b rd_valid=%0b, exp 0 0 0 0",
               st_state, st_count, st_overflow, rd_valid);
      fails++;
    end
  endtask

  task automatic test_trigger_post();
    cfg_trig_en = 1'b1; cfg_trig_addr = 32'h104; cfg_post_cnt = 2'd1;
    arm = 1'b1; tick(); arm = 1'b0;
    tests++;
    if (st_state !== 2'd1) begin
      $display("FAIL arm_to_pre: got %0d exp 1", st_state); fails++;
    end
    drive_resp(32'h100, 5'd0, 1'b0); tick();
    tests++;
    if (st_count !== 3'd1 || st_state !== 2'd1) begin
      $display("FAIL first_capture: got count=%0d state=%0d exp 1 1", st_count, st_state); fails++;
    end
    drive_resp(32'h104, 5'd0, 1'b0); tick();
    tests++;
    if (st_state !== 2'd2 || st_count !== 3'd2) begin
      $display("FAIL hit_to_post: got state=%0d count=%0d exp 2 2", st_state, st_count); fails++;
    end
    drive_resp(32'h108, 5'd0, 1'b0); tick();
    resp_valid = 1'b0;
    tests++;
    if (st_state !== 2'd3 || st_count !== 3'd3 || rd_valid !== 1'b1) begin
      $display("FAIL post_to_done: got state=%0d count=%0d rd_valid=%0b exp 3 3 1",
               st_state, st_count, rd_valid); fails++;
    end
    tests++;
    if (rd_data[63:32] !== 32'h100 || rd_data[31:0] !== ~32'h100) begin
      $display("FAIL pop0_data: got addr=%h rdata=%h exp 00000100 %h",
               rd_data[63:32], rd_data[31:0], ~32'h100); fails++;
    end
    rd_ready = 1'b1; tick();
    tests++;
    if (st_count !== 3'd2 || rd_data[63:32] !== 32'h104) begin
      $display("FAIL pop1_data: got count=%0d addr=%h exp 2 00000104", st_count, rd_data[63:32]); fails++;
    end
    tick();
    tests++;
    if (st_count !== 3'd1 || rd_data[63:32] !== 32'h108) begin
      $display("FAIL pop2_data: got count=%0d addr=%h exp 1 00000108", st_count, rd_data[63:32]); fails++;
    end
    tick();
    rd_ready = 1'b0;
    tests++;
    if (st_count !== 3'd0 || rd_valid !== 1'b0 || st_state !== 2'd3) begin
      $display("FAIL drained: got count=%0d rd_valid=%0b state=%0d exp 0 0 3",
               st_count, rd_valid, st_state); fails++;
    end
  endtask

  task automatic test_rolling_window();
    cfg_trig_en = 1'b0; cfg_post_cnt = 2'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_resp(32'h1000 + 32'(16 * k), 5'd0, 1'b0);
      arm = (k == 5);
      tick();
    end
    arm = 1'b0; resp_valid = 1'b0;
    tests++;
    if (st_count !== 3'd4 || st_overflow !== 1'b1 || st_state !== 2'd1) begin
      $display("FAIL rolling_overflow: got count=%0d ovf=%0b state=%0d exp 4 1 1",
               st_count, st_overflow, st_state); fails++;
    end
    abort = 1'b1; rd_ready = 1'b0; tick(); abort = 1'b0;
    tests++;
    if (st_state !== 2'd0 || st_count !== 3'd0) begin
      $display("FAIL abort_pre: got state=%0d count=%0d exp 0 0", st_state, st_count); fails++;
    end
    cfg_trig_en = 1'b1; cfg_trig_addr = 32'h1050; cfg_post_cnt = 2'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    tests++;
    if (st_overflow !== 1'b0) begin
      $display("FAIL arm_clears_ovf: got %0b exp 0", st_overflow); fails++;
    end
    for (int k = 0; k < 6; k++) begin
      drive_resp(32'h1000 + 32'(16 * k), 5'd0, 1'b0);
      tick();
    end
    resp_valid = 1'b0;
    tests++;
    if (st_state !== 2'd3 || st_count !== 3'd4 || st_overflow !== 1'b1) begin
      $display("FAIL trig_full_done: got state=%0d count=%0d ovf=%0b exp 3 4 1",
               st_state, st_count, st_overflow); fails++;
    end
    tests++;
    if (rd_data[63:32] !== 32'h1020) begin
      $display("FAIL oldest_of_four: got addr=%h exp 00001020", rd_data[63:32]); fails++;
    end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    tests++;
    if (rd_data[63:32] !== 32'h1030 || st_count !== 3'd3) begin
      $display("FAIL second_of_four: got addr=%h count=%0d exp 00001030 3", rd_data[63:32], st_count); fails++;
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_filter();
    cfg_cmd_mask = 32'h2; cfg_miss_only = 1'b1;
    cfg_trig_en = 1'b1; cfg_trig_addr = 32'h5C; cfg_post_cnt = 2'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    drive_resp(32'h5C, 5'd0, 1'b1); tick();
    tests++;
    if (st_count !== 3'd0 || st_state !== 2'd1) begin
      $display("FAIL filt_load_miss: got count=%0d state=%0d exp 0 1", st_count, st_state); fails++;
    end
    drive_resp(32'h5C, 5'd1, 1'b0); tick();
    tests++;
    if (st_count !== 3'd0 || st_state !== 2'd1) begin
      $display("FAIL filt_store_hit: got count=%0d state=%0d exp 0 1", st_count, st_state); fails++;
    end
    drive_resp(32'h5C, 5'd1, 1'b1); tick();
    resp_valid = 1'b0;
    tests++;
    if (st_count !== 3'd1 || st_state !== 2'd3) begin
      $display("FAIL filt_store_miss: got count=%0d state=%0d exp 1 3", st_count, st_state); fails++;
    end
    tests++;
    if (rd_data[75:71] !== 5'd1 || rd_data[80] !== 1'b1 || rd_data[63:32] !== 32'h5C) begin
      $display("FAIL filt_entry: got cmd=%0d miss=%0b addr=%h exp 1 1 0000005c",
               rd_data[75:71], rd_data[80], rd_data[63:32]); fails++;
    end
    cfg_cmd_mask = 32'hFFFF_FFFF; cfg_miss_only = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    cfg_trig_en = 1'b1; cfg_trig_addr = 32'h2004; cfg_post_cnt = 2'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    drive_resp(32'h2000, 5'd0, 1'b0); tick();
    drive_resp(32'h2004, 5'd0, 1'b0); tick();
    resp_valid = 1'b0;
    rd_ready = 1'b1;
    tests++;
    if (rd_valid !== 1'b1 || st_count !== 3'd2) begin
      $display("FAIL b2b_cycle0: got rd_valid=%0b count=%0d exp 1 2", rd_valid, st_count); fails++;
    end
    tick();
    tests++;
    if (rd_valid !== 1'b1 || st_count !== 3'd1) begin
      $display("FAIL b2b_cycle1: got rd_valid=%0b count=%0d exp 1 1", rd_valid, st_count); fails++;
    end
    tick();
    tests++;
    if (rd_valid !== 1'b0 || st_count !== 3'd0) begin
      $display("FAIL b2b_cycle2: got rd_valid=%0b count=%0d exp 0 0", rd_valid, st_count); fails++;
    end
    rd_ready = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    drive_resp(32'h2100, 5'd0, 1'b0); tick();
    tests++;
    if (st_state !== 2'd1 || st_count !== 3'd1) begin
      $display("FAIL rearm_from_done: got state=%0d count=%0d exp 1 1", st_state, st_count); fails++;
    end
    drive_resp(32'h2004, 5'd0, 1'b0);
    arm = 1'b1; abort = 1'b1; tick();
    arm = 1'b0; abort = 1'b0; resp_valid = 1'b0;
    tests++;
    if (st_state !== 2'd0 || st_count !== 3'd0) begin
      $display("FAIL abort_wins: got state=%0d count=%0d exp 0 0", st_state, st_count); fails++;
    end
  endtask

  task automatic test_reset_mid_capture();
    cfg_trig_en = 1'b1; cfg_trig_addr = 32'h3004; cfg_post_cnt = 2'd2;
    arm = 1'b1; tick(); arm = 1'b0;
    drive_resp(32'h3000, 5'd0, 1'b0); tick();
    drive_resp(32'h3004, 5'd0, 1'b0); tick();
    drive_resp(32'h3008, 5'd0, 1'b0); tick();
    resp_valid = 1'b0;
    tests++;
    if (st_state !== 2'd2 || st_count !== 3'd3) begin
      $display("FAIL post_count3: got state=%0d count=%0d exp 2 3", st_state, st_count); fails++;
    end
    reset = 1'b1; tick();
    tests++;
    if (st_state !== 2'd0 || st_count !== 3'd0 || rd_valid !== 1'b0 || st_overflow !== 1'b0) begin
      $display("FAIL reset_mid: got state=%0d count=%0d rd_valid=%0b ovf=%0b exp 0 0 0 0",
               st_state, st_count, rd_valid, st_overflow); fails++;
    end
    reset = 1'b0;
    cfg_trig_addr = 32'h3104; cfg_post_cnt = 2'd1;
    arm = 1'b1; tick(); arm = 1'b0;
    drive_resp(32'h3100, 5'd0, 1'b1);
    resp_id = 7'h55; resp_rdata = 32'hCAFE_F00D; resp_signed = 1'b1; resp_size = 2'd2;
    tick();
    drive_resp(32'h3104, 5'd0, 1'b0); tick();
    drive_resp(32'h3108, 5'd0, 1'b0); tick();
    resp_valid = 1'b0;
    exp_e = {16'd1, 1'b1, 1'b1, 1'b1, 2'd2, 5'd0, 7'h55, 32'h3100, 32'hCAFE_F00D};
    tests++;
    if (rd_data !== exp_e || st_state !== 2'd3) begin
      $display("FAIL full_entry_ts1: got %h state=%0d exp %h 3", rd_data, st_state, exp_e); fails++;
    end
    rd_ready = 1'b1; tick();
    tests++;
    if (rd_data[96:81] !== 16'd2) begin
      $display("FAIL ts_second: got %0d exp 2", rd_data[96:81]); fails++;
    end
    tick(); rd_ready = 1'b0;
    tests++;
    if (rd_data[96:81] !== 16'd3 || rd_data[63:32] !== 32'h3108) begin
      $display("FAIL ts_third: got ts=%0d addr=%h exp 3 00003108", rd_data[96:81], rd_data[63:32]); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_trigger_post();
    test_rolling_window();
    test_filter();
    test_back_to_back();
    test_reset_mid_capture();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sifive_scope_dcache_resp_trace.md
SIFIVE_SCOPE_DCACHE_RESP_TRACE -- requirements
Module: sifive_scope_dcache_resp_trace

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, response address width.
REQ-002 SHALL provide parameter DATA_W, default 32, load data width.
REQ-003 SHALL provide parameter ID_W, default 7, cache transaction id width.
REQ-004 SHALL provide parameter DEPTH, default 16, trace entries; power of two, >=2; PW=log2(DEPTH).
REQ-005 SHALL provide parameter TS_W, default 16, timestamp width.
REQ-006 Ports SHALL be: clock  in  1  single clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 resp_valid, resp_miss, resp_has_data, resp_signed  in  1 each  monitored DCache response fields.
REQ-009 resp_addr  in  ADDR_W; resp_rdata  in  DATA_W; resp_id  in  ID_W; resp_cmd  in  5  M_* encoding; resp_size  in  2  log2 bytes.
REQ-010 cfg_cmd_mask  in  32  bit n enables capture of cmd n; cfg_miss_only  in  1  capture misses only.
REQ-011 cfg_trig_en  in  1; cfg_trig_addr  in  ADDR_W; cfg_trig_mask  in  ADDR_W  1=compare bit; cfg_post_cnt  in  PW  entries after trigger.
REQ-012 arm  in  1  start capture pulse; abort  in  1  return to IDLE pulse.
REQ-013 rd_valid  out  1; rd_ready  in  1; rd_data  out  E_W  oldest entry, E_W=TS_W+10+ID_W+ADDR_W+DATA_W.
REQ-014 st_state  out  2  IDLE=0 PRE=1 POST=2 DONE=3; st_count  out  PW+1  valid entries; st_overflow  out  1  sticky.
REQ-015 rd_data packing SHALL be MSB->LSB {ts, miss, has_data, signed, size, cmd, id, addr, rdata}.

Function
REQ-016 Free-running ts counter SHALL increment every cycle, wrap 2^TS_W-1 -> 0; entry ts = value in capture cycle.
REQ-017 qual SHALL be resp_valid & cfg_cmd_mask[resp_cmd] & (~cfg_miss_only | resp_miss).
REQ-018 hit SHALL be qual & cfg_trig_en & (((resp_addr ^ cfg_trig_addr) & cfg_trig_mask) == 0).
REQ-019 Capture SHALL occur only in PRE/POST when qual=1: write at wptr, wptr+1 mod DEPTH, count+1 saturating at DEPTH.
REQ-020 Capture at count==DEPTH SHALL overwrite oldest entry and set st_overflow.
REQ-021 IDLE: arm -> PRE, clearing wptr, count, st_overflow, post counter; no capture in arm cycle.
REQ-022 PRE: hit captures the triggering response; cfg_post_cnt==0 -> DONE, else -> POST with remain=cfg_post_cnt (sampled at hit).
REQ-023 POST: each qual captures and decrements remain; capture with remain==1 -> DONE; hit in POST is treated as plain qual.
REQ-024 DONE: no capture; rd_valid = (count!=0); rd_data = entry at (wptr-count) mod DEPTH, combinational from storage.
REQ-025 rd_valid & rd_ready SHALL pop one entry (count-1) per cycle; rd_valid SHALL be 0 outside DONE and rd_ready ignored.
REQ-026 arm in DONE -> PRE as REQ-021 (unread entries discarded); arm in PRE/POST ignored.
REQ-027 abort in any state -> IDLE, count=0; abort SHALL win over simultaneous arm, hit or pop.
REQ-028 cfg_trig_en=0 in PRE SHALL keep capturing indefinitely (rolling window of last DEPTH entries).
REQ-029 Latency: capture visible in st_count next cycle; state change takes effect next cycle.

Reset
REQ-030 reset SHALL set state IDLE, wptr 0, count 0, st_overflow 0, ts 0, rd_valid 0; storage contents need not reset.
REQ-031 reset mid-capture or mid-readout SHALL discard all entries with the REQ-030 values next cycle.

Verification (DEPTH=4, cfg_cmd_mask=0xFFFFFFFF, cfg_miss_only=0)
REQ-032 arm; 3 loads addr 0x100,0x104,0x108, trig_addr=0x104 mask=0xFFFFFFFF, post_cnt=1 -> DONE after 0x108; pops return 0x100,0x104,0x108; count 3->0.
REQ-033 trig_en=0; 6 qual responses A..F -> st_count=4, st_overflow=1; abort; trig_en=1 matching F re-armed -> first pop after trigger returns oldest of last 4.
REQ-034 cfg_cmd_mask=0x2 (store only), cfg_miss_only=1: load miss, store hit, store miss -> only the store miss captured, count=1.
REQ-035 DONE with count=2, rd_ready held 1 -> rd_valid 1,1,0 across three cycles; arm asserted with abort same cycle -> IDLE, count 0.
REQ-036 reset asserted in POST with count=3 -> next cycle st_state=0, st_count=0, rd_valid=0; ts restarts at 0,1,2.
